toggle_monitor: RTL

Receive-side checker for toggle-pattern outputs such as the toggle flops and bounded toggle counters in this design. It synchronises an asynchronous toggling input, detects each transition and counts transitions up to a limit. It measures the spacing between transitions and flags a stall when toggling stops. It sits beside any toggle source under test and reports status on registered outputs.

---
 rtl/toggle_monitor_if.sv | 24 ++
 rtl/toggle_monitor.sv | 104 ++++++++++
 2 files changed

// File: rtl/toggle_monitor_if.sv
// Observation bus between a toggle source and its monitor.
// The monitor side takes the slave modport; the stimulus/observer side takes master.
interface toggle_monitor_if #(
  parameter int CNT_W = 8
);
  logic             toggle_in;
  logic             clear;
  logic             edge_pulse;
  logic [CNT_W-1:0] toggle_count;
  logic [CNT_W-1:0] period;
  logic             active;
  logic             limit_reached;
  logic             stalled;

  modport master (
    output toggle_in, clear,
    input  edge_pulse, toggle_count, period, active, limit_reached, stalled
  );

  modport slave (
    input  toggle_in, clear,
    output edge_pulse, toggle_count, period, active, limit_reached, stalled
  );
endinterface

// File: rtl/toggle_monitor.sv
// Synchronises an asynchronous toggle, counts transitions up to a limit,
// measures edge spacing and flags a stall when toggling stops.
module toggle_monitor #(
  parameter int MAX_TOGGLES = 5,
  parameter int TIMEOUT     = 16,
  parameter int CNT_W       = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  toggle_monitor_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, ACTIVE, STALLED, LIMIT} state_t;

  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] SAT   = '1;
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_TOGGLES);
  localparam logic [CNT_W-1:0] TO_C  = CNT_W'(TIMEOUT);

  // sync_q[0]=s1, sync_q[1]=s2, sync_q[2]=history flop s3
  logic [2:0]       sync_q;
  logic             raw_edge;

  state_t           state_q, state_nxt;
  logic [CNT_W-1:0] count_q, count_nxt;
  logic [CNT_W-1:0] period_q, period_nxt;
  logic [CNT_W-1:0] gap_q, gap_nxt;
  logic [CNT_W-1:0] gap_inc, cnt_inc;
  logic             pulse_q, pulse_nxt;
  logic             active_q, limit_q, stalled_q;

  assign raw_edge = sync_q[1] ^ sync_q[2];
  assign gap_inc  = (gap_q == SAT) ? SAT : gap_q + ONE;
  assign cnt_inc  = count_q + ONE;

  always_comb begin
    state_nxt  = state_q;
    count_nxt  = count_q;
    period_nxt = period_q;
    gap_nxt    = gap_inc;
    pulse_nxt  = raw_edge;
    if (bus.clear) begin
      state_nxt  = IDLE;
      count_nxt  = '0;
      period_nxt = '0;
      gap_nxt    = '0;
      pulse_nxt  = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (raw_edge) begin
          count_nxt = ONE;
          gap_nxt   = '0;
          state_nxt = (ONE >= MAX_C) ? LIMIT : ACTIVE;
        end
        ACTIVE, STALLED: begin
          if (raw_edge) begin
            // gap_inc already saturates, so a long stall reads back as all-ones
            count_nxt  = cnt_inc;
            period_nxt = gap_inc;
            gap_nxt    = '0;
            state_nxt  = (cnt_inc >= MAX_C) ? LIMIT : ACTIVE;
          end else if (state_q == ACTIVE && gap_inc == TO_C) begin
            state_nxt = STALLED;
          end
        end
        LIMIT: if (raw_edge) gap_nxt = '0;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q    <= '0;
      state_q   <= IDLE;
      count_q   <= '0;
      period_q  <= '0;
      gap_q     <= '0;
      pulse_q   <= 1'b0;
      active_q  <= 1'b0;
      limit_q   <= 1'b0;
      stalled_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[1:0], bus.toggle_in};
      state_q   <= state_nxt;
      count_q   <= count_nxt;
      period_q  <= period_nxt;
      gap_q     <= gap_nxt;
      pulse_q   <= pulse_nxt;
      // flags decode the next state so they change on the same edge as the state
      active_q  <= (state_nxt == ACTIVE);
      limit_q   <= (state_nxt == LIMIT);
      stalled_q <= (state_nxt == STALLED);
    end
  end

  assign bus.edge_pulse    = pulse_q;
  assign bus.toggle_count  = count_q;
  assign bus.period        = period_q;
  assign bus.active        = active_q;
  assign bus.limit_reached = limit_q;
  assign bus.stalled       = stalled_q;

endmodule
